// File: rtl/conv_8_sdiv_24s_8s_16s.sv
// conv_8_sdiv_24s_8s_16s
// Sequential signed divider that requantizes conv_8 accumulators back to
// feature-map width. Radix-2 restoring on operand magnitudes, one quotient
// bit per cycle, signs applied afterwards with C truncation semantics and
// saturation of the quotient. Valid/ready handshake on both sides.
module conv_8_sdiv_24s_8s_16s #(
   parameter logic [31:0] ID             = 32'd1,
   parameter int unsigned DIVIDEND_WIDTH = 24,
   parameter int unsigned DIVISOR_WIDTH  = 8,
   parameter int unsigned QUOTIENT_WIDTH = 16
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DIVIDEND_WIDTH-1:0] din0,
   input  logic [DIVISOR_WIDTH-1:0]  din1,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [QUOTIENT_WIDTH-1:0] dout,
   output logic [DIVISOR_WIDTH-1:0]  rem,
   output logic                      ovf,
   output logic                      div_by_zero
);

   localparam int unsigned DW = DIVIDEND_WIDTH;
   localparam int unsigned VW = DIVISOR_WIDTH;
   localparam int unsigned QW = QUOTIENT_WIDTH;
   localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   // Largest positive / negative quotient magnitudes representable in QW bits
   localparam logic [DW-1:0] POS_LIM = {{(DW-QW+1){1'b0}}, {(QW-1){1'b1}}};
   localparam logic [DW-1:0] NEG_LIM = POS_LIM + DW'(1);
   localparam logic [QW-1:0] SAT_MAX = {1'b0, {(QW-1){1'b1}}};
   localparam logic [QW-1:0] SAT_MIN = {1'b1, {(QW-1){1'b0}}};

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] dvd_q, dvd_d;     // dividend magnitude, consumed MSB first
   logic [VW-1:0] dvs_q, dvs_d;     // divisor magnitude
   logic [VW-1:0] prem_q, prem_d;   // partial remainder magnitude
   logic [DW-1:0] quo_q, quo_d;     // quotient magnitude
   logic          sa_q, sa_d;       // dividend sign
   logic          sb_q, sb_d;       // divisor sign
   logic          zero_q, zero_d;   // divisor was zero
   logic [QW-1:0] dout_q, dout_d;
   logic [VW-1:0] rem_q, rem_d;
   logic          ovf_q, ovf_d;
   logic          dbz_q, dbz_d;

   logic [VW:0]   trial;
   logic          fits;
   logic [DW-1:0] din0_mag;
   logic [VW-1:0] din1_mag;
   logic          q_neg;
   logic          q_ovf;
   logic [QW-1:0] q_low;
   logic [QW-1:0] fix_dout;
   logic [VW-1:0] fix_rem;

   assign in_ready    = (state_q == S_IDLE);
   assign out_valid   = (state_q == S_DONE);
   assign dout        = dout_q;
   assign rem         = rem_q;
   assign ovf         = ovf_q;
   assign div_by_zero = dbz_q;

   // Operand magnitudes; an unsigned DW-bit magnitude already holds 2^(DW-1),
   // so the most negative dividend (and divisor) converts exactly.
   always_comb begin
      din0_mag = din0[DW-1] ? (~din0 + DW'(1)) : din0;
      din1_mag = din1[VW-1] ? (~din1 + VW'(1)) : din1;
   end

   // Sign application, C-style truncation and quotient saturation
   always_comb begin
      q_neg = sa_q ^ sb_q;
      q_ovf = q_neg ? (quo_q > NEG_LIM) : (quo_q > POS_LIM);
      q_low = quo_q[QW-1:0];
      fix_rem = sa_q ? (~prem_q + VW'(1)) : prem_q;
      if (q_ovf) begin
         fix_dout = q_neg ? SAT_MIN : SAT_MAX;
      end else begin
         fix_dout = q_neg ? (~q_low + QW'(1)) : q_low;
      end
   end

   // Next-state and datapath: accept, iterate, fix up, hold result
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      prem_d  = prem_q;
      quo_d   = quo_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      zero_d  = zero_q;
      dout_d  = dout_q;
      rem_d   = rem_q;
      ovf_d   = ovf_q;
      dbz_d   = dbz_q;

      trial = {prem_q, dvd_q[DW-1]};
      fits  = (trial >= {1'b0, dvs_q});

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               dvd_d   = din0_mag;
               dvs_d   = din1_mag;
               sa_d    = din0[DW-1];
               sb_d    = din1[VW-1];
               zero_d  = (din1 == '0);
               prem_d  = '0;
               quo_d   = '0;
               cnt_d   = CW'(DW - 1);
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            // A zero divisor simply runs the full iteration count so latency
            // stays constant; its remainder/quotient are discarded in FIX.
            prem_d = fits ? VW'(trial - {1'b0, dvs_q}) : trial[VW-1:0];
            quo_d  = {quo_q[DW-2:0], fits};
            dvd_d  = {dvd_q[DW-2:0], 1'b0};
            if (cnt_q == '0) begin
               state_d = S_FIX;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_FIX: begin
            if (zero_q) begin
               dout_d = sa_q ? SAT_MIN : SAT_MAX;
               rem_d  = '0;
               ovf_d  = 1'b0;
               dbz_d  = 1'b1;
            end else begin
               dout_d = fix_dout;
               rem_d  = fix_rem;
               ovf_d  = q_ovf;
               dbz_d  = 1'b0;
            end
            state_d = S_DONE;
         end
         default: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   // State and result registers with synchronous reset
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         prem_q  <= '0;
         quo_q   <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         zero_q  <= 1'b0;
         dout_q  <= '0;
         rem_q   <= '0;
         ovf_q   <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         prem_q  <= prem_d;
         quo_q   <= quo_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         zero_q  <= zero_d;
         dout_q  <= dout_d;
         rem_q   <= rem_d;
         ovf_q   <= ovf_d;
         dbz_q   <= dbz_d;
      end
   end

endmodule
